// File: rtl/ramb4_s1_loader_pkg.sv
// rtl/ramb4_s1_loader_pkg.sv - shared types, widths and helpers for the RAMB4_S1 byte loader (RAMB4_S1_LOADER_READBACK_EN)
package ramb4_s1_loader_pkg;

  localparam int BYTE_W      = 8;
  localparam int BIT_IDX_W   = 3;
  localparam int BYTE_ADDR_W = 9;
  localparam int RAM_ADDR_W  = 12;

  // Read states exist only when the readback path is built.
`ifdef RAMB4_S1_LOADER_READBACK_EN
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ_ISSUE = 3'd2,
    READ_DRAIN = 3'd3,
    RESP       = 3'd4
  } loader_state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1
  } loader_state_e;
`endif

  // Bit that lands at bit index 0 of a byte slot for the chosen bit order.
  function automatic logic first_bit(input logic [BYTE_W-1:0] data, input logic msb_first);
    return msb_first ? data[BYTE_W-1] : data[0];
  endfunction

endpackage

// File: rtl/ramb4_s1_shift8.sv
// rtl/ramb4_s1_shift8.sv - 8-bit shift register: parallel load for write serialise, serial-in shift for read deserialise
module ramb4_s1_shift8
  import ramb4_s1_loader_pkg::*;
#(
  parameter bit BIT_ORDER_MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] load_data_i,
  input  logic              shift_i,
  input  logic              ser_i,
  output logic [BYTE_W-1:0] shifted_o
);

  logic [BYTE_W-1:0] data_q;

  // One shift direction serves both paths: the outgoing head bit is the next
  // RAM bit on writes, and the incoming serial bit fills the opposite end on reads.
  always_comb begin
    shifted_o = BIT_ORDER_MSB_FIRST ? {data_q[BYTE_W-2:0], ser_i}
                                    : {ser_i, data_q[BYTE_W-1:1]};
  end

  // Register: load wins over shift.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= shifted_o;
    end
  end

endmodule

// File: rtl/ramb4_s1_byte_loader.sv
// rtl/ramb4_s1_byte_loader.sv - byte-wide command front end for a 4096x1 RAMB4_S1 (RAMB4_S1_LOADER_READBACK_EN enables reads)
module ramb4_s1_byte_loader
  import ramb4_s1_loader_pkg::*;
#(
  parameter bit BIT_ORDER_MSB_FIRST = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [BYTE_ADDR_W-1:0] cmd_addr,
  input  logic [BYTE_W-1:0]      cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [BYTE_W-1:0]      rsp_data,
  output logic [RAM_ADDR_W-1:0]  ram_addr,
  output logic                   ram_di,
  output logic                   ram_en,
  output logic                   ram_we,
  input  logic                   ram_do,
  output logic                   busy
);

  loader_state_e          state_q, state_d;
  logic [BIT_IDX_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_ADDR_W-1:0] byte_addr_q, byte_addr_d;
  logic [RAM_ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   ram_di_q, ram_di_d;
  logic                   ram_en_q, ram_en_d;
  logic                   ram_we_q, ram_we_d;
  logic                   sr_load, sr_shift, sr_ser;
  logic [BYTE_W-1:0]      sr_shifted;
  logic                   cmd_accept;

`ifdef RAMB4_S1_LOADER_READBACK_EN
  logic                   rsp_valid_q, rsp_valid_d;
  logic [BYTE_W-1:0]      rsp_data_q, rsp_data_d;

  assign sr_ser    = ram_do;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  logic unused_ram_do;
  logic unused_rsp_ready;

  assign sr_ser           = 1'b0;
  assign rsp_valid        = 1'b0;
  assign rsp_data         = '0;
  assign unused_ram_do    = ram_do;
  assign unused_rsp_ready = rsp_ready;
`endif

  assign cmd_accept = cmd_valid && cmd_ready_q;
  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign ram_addr   = ram_addr_q;
  assign ram_di     = ram_di_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;

  ramb4_s1_shift8 #(
    .BIT_ORDER_MSB_FIRST(BIT_ORDER_MSB_FIRST)
  ) u_shift (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (sr_load),
    .load_data_i(cmd_data),
    .shift_i    (sr_shift),
    .ser_i      (sr_ser),
    .shifted_o  (sr_shifted)
  );

  // Next state and next registered outputs; RAM pins are computed one cycle
  // ahead so every pin comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_addr_d = byte_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_di_d    = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
`ifdef RAMB4_S1_LOADER_READBACK_EN
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          if (cmd_write) begin
            state_d     = WRITE;
            bit_cnt_d   = '0;
            byte_addr_d = cmd_addr;
            ram_addr_d  = {cmd_addr, 3'd0};
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_di_d    = first_bit(cmd_data, BIT_ORDER_MSB_FIRST);
            sr_load     = 1'b1;
          end
`ifdef RAMB4_S1_LOADER_READBACK_EN
          else begin
            state_d     = READ_ISSUE;
            bit_cnt_d   = '0;
            byte_addr_d = cmd_addr;
            ram_addr_d  = {cmd_addr, 3'd0};
            ram_en_d    = 1'b1;
          end
`endif
        end
      end

      WRITE: begin
        sr_shift = 1'b1;
        if (bit_cnt_q == 3'd7) begin
          state_d = IDLE;
        end else begin
          bit_cnt_d  = bit_cnt_q + 3'd1;
          ram_addr_d = {byte_addr_q, bit_cnt_q + 3'd1};
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_di_d   = first_bit(sr_shifted, BIT_ORDER_MSB_FIRST);
        end
      end

`ifdef RAMB4_S1_LOADER_READBACK_EN
      READ_ISSUE: begin
        // DO lags the issued address by one cycle, so nothing is captured
        // on the edge that ends the first issue cycle.
        sr_shift = (bit_cnt_q != 3'd0);
        if (bit_cnt_q == 3'd7) begin
          state_d = READ_DRAIN;
        end else begin
          bit_cnt_d  = bit_cnt_q + 3'd1;
          ram_addr_d = {byte_addr_q, bit_cnt_q + 3'd1};
          ram_en_d   = 1'b1;
        end
      end

      READ_DRAIN: begin
        sr_shift    = 1'b1;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = sr_shifted;
      end

      RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset clears everything, so cmd_ready
  // first rises on the edge after reset is released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_addr_q <= '0;
      ram_addr_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      ram_di_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_addr_q <= byte_addr_d;
      ram_addr_q  <= ram_addr_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      ram_di_q    <= ram_di_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
    end
  end

`ifdef RAMB4_S1_LOADER_READBACK_EN
  // Response registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_ramb4_s1_byte_loader.sv
// tb/tb_ramb4_s1_byte_loader.sv - self-checking bench for ramb4_s1_byte_loader
module tb_ramb4_s1_byte_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        rsp_ready = 1'b0;
  logic        ram_do = 1'b0;

  logic        cmd_ready, rsp_valid, ram_di, ram_en, ram_we, busy;
  logic [7:0]  rsp_data;
  logic [11:0] ram_addr;

  logic        lsb_cmd_ready, lsb_rsp_valid, lsb_ram_di, lsb_ram_en, lsb_ram_we, lsb_busy;
  logic [7:0]  lsb_rsp_data;
  logic [11:0] lsb_ram_addr;

  logic        mem [0:4095] = '{default: 1'b0};

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  sb_q[$];

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [7:0]  data;
    int          hold;
    logic [11:0] base;
    logic [7:0]  exp_rsp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  always #5 CLK = ~CLK;

  ramb4_s1_byte_loader #(.BIT_ORDER_MSB_FIRST(1'b1)) u_dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_en(ram_en), .ram_we(ram_we),
    .ram_do(ram_do), .busy(busy)
  );

  ramb4_s1_byte_loader #(.BIT_ORDER_MSB_FIRST(1'b0)) u_dut_lsb (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(lsb_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(lsb_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(lsb_rsp_data),
    .ram_addr(lsb_ram_addr), .ram_di(lsb_ram_di), .ram_en(lsb_ram_en), .ram_we(lsb_ram_we),
    .ram_do(1'b0), .busy(lsb_busy)
  );

  // 4096x1 synchronous read-first RAM model
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_do <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop the expected byte when a response handshake is about to occur
  always @(negedge CLK) begin
    if (!RST) begin
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got data 0x%0h with empty scoreboard at %0t", rsp_data, $time);
        end else begin
          check("sb_rsp_data", 32'(rsp_data), 32'(sb_q.pop_front()));
        end
      end
      if (lsb_rsp_valid && rsp_ready) check("lsb_rsp_data", 32'(lsb_rsp_data), 32'd0);
    end
  end

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 40) begin
      @(negedge CLK);
      guard++;
    end
    check(name, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready("cmd_ready_pre");
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
`ifdef RAMB4_S1_LOADER_READBACK_EN
    if (!v.wr) begin
      sb_q.push_back(v.exp_rsp);
      rsp_ready = (v.hold == 0);
    end
`endif
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~v.wr;
    cmd_addr  = ~v.addr;
    cmd_data  = ~v.data;
    if (v.wr) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge CLK);
        check("wr_addr", 32'(ram_addr), 32'(v.base + 12'(i)));
        check("wr_di", 32'(ram_di), 32'(v.data[7-i]));
        check("wr_en_we", 32'({ram_en, ram_we}), 32'd3);
        check("wr_busy_ready", 32'({busy, cmd_ready}), 32'd2);
      end
      @(negedge CLK);
      check("wr_done_ready_busy", 32'({cmd_ready, busy}), 32'd2);
      check("wr_done_ram", 32'({ram_en, ram_we, ram_di}), 32'd0);
      check("wr_done_addr", 32'(ram_addr), 32'(v.base + 12'd7));
    end else begin
`ifdef RAMB4_S1_LOADER_READBACK_EN
      for (int i = 0; i < 8; i++) begin
        @(negedge CLK);
        check("rd_addr", 32'(ram_addr), 32'(v.base + 12'(i)));
        check("rd_en_we", 32'({ram_en, ram_we}), 32'd2);
        check("rd_busy_ready_rsp", 32'({busy, cmd_ready, rsp_valid}), 32'd4);
      end
      @(negedge CLK);
      check("rd_drain", 32'({ram_en, rsp_valid, busy}), 32'd1);
      check("rd_drain_addr", 32'(ram_addr), 32'(v.base + 12'd7));
      @(negedge CLK);
      check("rd_rsp_valid", 32'({rsp_valid, cmd_ready, ram_en}), 32'd4);
      check("rd_rsp_data", 32'(rsp_data), 32'(v.exp_rsp));
      if (v.hold == 0) begin
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
      end else begin
        for (int j = 0; j < v.hold; j++) begin
          @(negedge CLK);
          check("rd_hold_flags", 32'({rsp_valid, cmd_ready, ram_en, busy}), 32'd9);
          check("rd_hold_data", 32'(rsp_data), 32'(v.exp_rsp));
        end
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
      end
      @(negedge CLK);
      check("rd_idle", 32'({cmd_ready, busy, rsp_valid}), 32'd4);
`else
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        check("rd_off_ready_busy", 32'({cmd_ready, busy}), 32'd2);
        check("rd_off_ram_en", 32'(ram_en), 32'd0);
        check("rd_off_rsp_valid", 32'(rsp_valid), 32'd0);
      end
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 9'h003, 8'hA5, 0, 12'h018, 8'h00};
    vecs[1] = '{1'b1, 9'h1FF, 8'h3C, 0, 12'hFF8, 8'h00};
    vecs[2] = '{1'b0, 9'h1FF, 8'h00, 0, 12'hFF8, 8'h3C};
    vecs[3] = '{1'b1, 9'h0AB, 8'hC3, 0, 12'h558, 8'h00};
    vecs[4] = '{1'b0, 9'h0AB, 8'h00, 5, 12'h558, 8'hC3};
    vecs[5] = '{1'b0, 9'h003, 8'h00, 0, 12'h018, 8'hA5};
    vecs[6] = '{1'b0, 9'h100, 8'h00, 1, 12'h800, 8'h00};
    vecs[7] = '{1'b1, 9'h000, 8'hFF, 0, 12'h000, 8'h00};
    vecs[8] = '{1'b0, 9'h000, 8'h00, 2, 12'h000, 8'hFF};
    vecs[9] = '{1'b0, 9'h010, 8'h00, 0, 12'h080, 8'h00};

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    check("rst_flags", 32'({cmd_ready, busy, rsp_valid, ram_en, ram_we, ram_di}), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    RST = 1'b0;
    #1;
    check("rst_release_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge CLK);
    check("rst_release_ready_high", 32'(cmd_ready), 32'd1);

    // Table-driven commands
    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset during write cycle 4 aborts immediately
    wait_ready("abort_ready_pre");
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 9'h055;
    cmd_data  = 8'hFF;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("abort_addr", 32'(ram_addr), 32'(12'h2A8 + 12'(i)));
    end
    check("abort_pre_di", 32'(ram_di), 32'd1);
    RST = 1'b1;
    #1;
    check("abort_flags", 32'({cmd_ready, busy, rsp_valid, ram_en, ram_we, ram_di}), 32'd0);
    check("abort_addr_zero", 32'(ram_addr), 32'd0);
    @(negedge CLK);
    check("abort_hold_flags", 32'({cmd_ready, busy, rsp_valid, ram_en}), 32'd0);
    RST = 1'b0;
    #1;
    check("abort_release_low", 32'(cmd_ready), 32'd0);
    @(negedge CLK);
    check("abort_release_high", 32'({cmd_ready, busy, rsp_valid}), 32'd4);

    // LSB-first instance: write 0x01 to byte 0
    wait_ready("lsb_ready_pre");
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 9'h000;
    cmd_data  = 8'h01;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("lsb_addr", 32'(lsb_ram_addr), 32'(i));
      check("lsb_di", 32'(lsb_ram_di), 32'(i == 0));
      check("lsb_en_we", 32'({lsb_ram_en, lsb_ram_we}), 32'd3);
      check("msb_di_01", 32'(ram_di), 32'(i == 7));
    end
    @(negedge CLK);
    check("lsb_done", 32'({lsb_cmd_ready, lsb_busy, lsb_ram_en}), 32'd4);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
